md5_compress_core: RTL and testbench
====================================

MD5_COMPRESS_CORE -- requirements
Module: md5_compress_core

Interface
REQ-001 SHALL take parameter UNROLL, default 1, meaning MD5 steps computed per clock; legal values are 1, 2 and 4, and any other value SHALL fail elaboration.
REQ-002 SHALL take parameter W, default 32, meaning word width; it is fixed at 32 and any other value SHALL fail elaboration.
REQ-003 SHALL have clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have valid_i, input, 1 bit: a block request is present.
REQ-006 SHALL have ready_o, output, 1 bit: the core accepts a block.
REQ-007 SHALL have M_i, input, 16x32: message block, little-endian words M[0..15].
REQ-008 SHALL have H_i, input, 4x32: chaining value {A,B,C,D}.
REQ-009 SHALL have init_i, input, 1 bit: when 1, use the MD5 IV instead of H_i.
REQ-010 SHALL have valid_o, output, 1 bit: the digest is valid.
REQ-011 SHALL have ready_i, input, 1 bit: the consumer accepts the digest.
REQ-012 SHALL have H_o, output, 4x32: updated chaining value.
REQ-013 SHALL have busy_o, output, 1 bit: the state is not IDLE.

Function
REQ-014 SHALL implement the FSM IDLE -> RUN -> FIN -> DONE -> IDLE.
REQ-015 SHALL assert ready_o only in IDLE; a request is accepted when valid_i and ready_o are both 1.
REQ-016 SHALL, on acceptance, register M_i, register H_i or the IV (per init_i) into both the working regs A..D and the saved chain, clear the step counter and enter RUN.
REQ-017 SHALL, in RUN, perform UNROLL chained MD5 steps per cycle, with step index i = 0..63; the round is i[5:4].
REQ-018 SHALL use these round functions: F=(B&C)|(~B&D), G=(B&D)|(C&~D), H=B^C^D, I=C^(B|~D).
REQ-019 SHALL use these message indices: g=i; (5i+1) mod 16; (3i+5) mod 16; 7i mod 16 for rounds 0-3 respectively.
REQ-020 SHALL compute each step as B' = B + rotl(A+f+K[i]+M[g], S[i]), A'=D, C'=B, D'=C, with all sums modulo 2^32 and carries discarded.
REQ-021 SHALL use the standard rotate amounts: round 0 {7,12,17,22}, round 1 {5,9,14,20}, round 2 {4,11,16,23}, round 3 {6,10,15,21}, indexed by i mod 4.
REQ-022 SHALL leave RUN after 64/UNROLL cycles, i.e. after the cycle that completes step 63.
REQ-023 SHALL, in FIN, compute H_o = saved chain + {A,B,C,D} wordwise mod 2^32 in one cycle, then enter DONE.
REQ-024 SHALL hold valid_o=1 in DONE, with H_o stable until ready_i=1; on that cycle it SHALL return to IDLE.
REQ-025 SHALL have a latency from the acceptance edge to valid_o rising of 64/UNROLL+2 cycles (66, 34 or 18).
REQ-026 SHALL ignore valid_i while busy, with no queueing.
REQ-027 SHALL ignore valid_i and all of M_i, H_i and init_i outside the acceptance cycle; input changes during RUN SHALL NOT affect the result.
REQ-028 SHALL, with ready_i held 0, hold DONE indefinitely.
REQ-029 SHALL, when ready_i=1 on entry to DONE, produce a one-cycle valid_o pulse.
REQ-030 SHALL hold H_o at the last digest value outside DONE.

Reset
REQ-031 SHALL, on rst_i=0, immediately enter IDLE regardless of clock, including mid-RUN, discarding the block in progress.
REQ-032 SHALL set the reset values to: ready_o=1 after reset release, valid_o=0, busy_o=0, H_o=0, step counter=0, and working and saved regs=0.
REQ-033 SHALL accept a block on the first clock edge after rst_i deasserts when valid_i=1.

Structure
REQ-034 SHALL place in a shared package md5_pkg: the K[0..63] table, the S rotate table, the IV constants {0x67452301, 0xefcdab89, 0x98badcfe, 0x10325476}, and the state enum typedef.
REQ-035 SHALL contain one combinational sub-module md5_step (inputs A..D, M word, K, S, round; outputs the next A..D), instantiated UNROLL times in a chain.
REQ-036 SHALL derive the step index, g and S for each unrolled instance from the counter plus the instance offset.

Verification
REQ-037 SHALL test the empty string: init_i=1, M[0]=0x00000080, others 0 -> H_o = {0xd98c1dd4, 0x04b2008f, 0x980980e9, 0x7e42f8ec}.
REQ-038 SHALL test "abc": M[0]=0x80636261, M[14]=0x00000018, init_i=1 -> H_o = {0x98500190, 0xb04fd23c, 0x7d3f96d6, 0x727fe128}.
REQ-039 SHALL repeat both vectors for UNROLL=1, 2 and 4 -> identical digests, with valid_o at 66, 34 and 18 cycles after acceptance.
REQ-040 SHALL test backpressure: ready_i=0 for 20 cycles after valid_o -> valid_o and H_o held; ready_i=1 -> one-cycle handshake, then ready_o=1.
REQ-041 SHALL test reset at step 30: rst_i=0 -> valid_o=0 and ready_o=0 while rst_i=0, ready_o=1 after release; the next "abc" block yields the correct digest.
REQ-042 SHALL test busy input: valid_i held 1 and M_i changed during RUN -> only the first block is processed and its digest is unchanged.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared MD5 constants, state type and small helpers for the compression core.
package md5_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin,
        StDone
    } md5_state_e;

    // Initial chaining value; word 0 is A.
    localparam logic [3:0][31:0] MD5_IV = {
        32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301
    };

    localparam logic [31:0] MD5_K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts, indexed by {round, step mod 4}.
    localparam logic [4:0] MD5_S [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    // Message word index used by step i.
    function automatic logic [3:0] md5_msg_idx(input logic [5:0] i);
        logic [3:0] n;
        n = i[3:0];
        case (i[5:4])
            2'd0:    return n;
            2'd1:    return 4'(n * 4'd5 + 4'd1);
            2'd2:    return 4'(n * 4'd3 + 4'd5);
            default: return 4'(n * 4'd7);
        endcase
    endfunction

    // Rotate left; the upper half of the doubled word holds the rotated value.
    function automatic logic [31:0] md5_rotl(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] dbl;
        dbl = {x, x} << s;
        return dbl[63:32];
    endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: round function, add chain, rotate, word shuffle.
module md5_step
    import md5_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] m_i,
    input  logic [31:0] k_i,
    input  logic [4:0]  s_i,
    input  logic [1:0]  round_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] f;
    logic [31:0] sum;

    // Round function selection and the rotated sum feeding the new B.
    always_comb begin
        f = '0;
        unique case (round_i)
            2'd0: f = (b_i & c_i) | (~b_i & d_i);
            2'd1: f = (b_i & d_i) | (c_i & ~d_i);
            2'd2: f = b_i ^ c_i ^ d_i;
            2'd3: f = c_i ^ (b_i | ~d_i);
        endcase
        sum = a_i + f + k_i + m_i;
        a_o = d_i;
        b_o = b_i + md5_rotl(sum, s_i);
        c_o = b_i;
        d_o = c_i;
    end

endmodule

// File: rtl/md5_compress_core.sv
// MD5 compression of one 512-bit block, UNROLL steps per clock, valid/ready on both sides.
// Word 0 of H_i/H_o is A, word 3 is D.
module md5_compress_core
    import md5_pkg::*;
#(
    parameter int unsigned UNROLL = 1,
    parameter int unsigned W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [15:0][W-1:0]   M_i,
    input  logic [3:0][W-1:0]    H_i,
    input  logic                 init_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [3:0][W-1:0]    H_o,
    output logic                 busy_o
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("md5_compress_core: UNROLL must be 1, 2 or 4");
    end
    if (W != 32) begin : g_bad_width
        $error("md5_compress_core: W must be 32");
    end

    // Counter value at the start of the cycle that completes step 63.
    localparam logic [5:0] LastCnt = 6'(64 - UNROLL);

    md5_state_e          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [15:0][W-1:0]  m_q, m_d;
    logic [3:0][W-1:0]   work_q, work_d;
    logic [3:0][W-1:0]   chain_q, chain_d;
    logic [3:0][W-1:0]   h_q, h_d;

    // Step chain: element 0 is the registered state, element UNROLL the result.
    logic [W-1:0] a_s [UNROLL+1];
    logic [W-1:0] b_s [UNROLL+1];
    logic [W-1:0] c_s [UNROLL+1];
    logic [W-1:0] d_s [UNROLL+1];

    assign a_s[0] = work_q[0];
    assign b_s[0] = work_q[1];
    assign c_s[0] = work_q[2];
    assign d_s[0] = work_q[3];

    for (genvar j = 0; j < UNROLL; j++) begin : g_step
        logic [5:0] idx;
        logic [3:0] g;
        assign idx = cnt_q + 6'(j);
        assign g   = md5_msg_idx(idx);

        md5_step u_step (
            .a_i     (a_s[j]),
            .b_i     (b_s[j]),
            .c_i     (c_s[j]),
            .d_i     (d_s[j]),
            .m_i     (m_q[g]),
            .k_i     (MD5_K[idx]),
            .s_i     (MD5_S[{idx[5:4], idx[1:0]}]),
            .round_i (idx[5:4]),
            .a_o     (a_s[j+1]),
            .b_o     (b_s[j+1]),
            .c_o     (c_s[j+1]),
            .d_o     (d_s[j+1])
        );
    end

    // Held low during reset so no block is offered while the core is cleared.
    assign ready_o = (state_q == StIdle) && rst_i;
    assign busy_o  = (state_q != StIdle);
    assign valid_o = (state_q == StDone);
    assign H_o     = h_q;

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        work_d  = work_q;
        chain_d = chain_q;
        h_d     = h_q;
        case (state_q)
            StIdle: begin
                if (valid_i && ready_o) begin
                    m_d     = M_i;
                    work_d  = init_i ? MD5_IV : H_i;
                    chain_d = init_i ? MD5_IV : H_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                work_d[0] = a_s[UNROLL];
                work_d[1] = b_s[UNROLL];
                work_d[2] = c_s[UNROLL];
                work_d[3] = d_s[UNROLL];
                cnt_d     = cnt_q + 6'(UNROLL);
                if (cnt_q == LastCnt) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                for (int j = 0; j < 4; j++) begin
                    h_d[j] = chain_q[j] + work_q[j];
                end
                state_d = StDone;
            end
            StDone: begin
                if (ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            m_q     <= '0;
            work_q  <= '0;
            chain_q <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            work_q  <= work_d;
            chain_q <= chain_d;
            h_q     <= h_d;
        end
    end

endmodule

// File: tb/tb_md5_compress_core.sv
// Scoreboard bench: three cores (UNROLL 1, 2, 4) share stimulus; each has its own monitor lane.
module tb_md5_compress_core;
    import md5_pkg::*;

    localparam logic [3:0][31:0] DIG_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [3:0][31:0] DIG_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic valid_i = 1'b0;
    logic init_i = 1'b0;
    logic ready_i = 1'b1;
    logic [15:0][31:0] m_i = '0;
    logic [3:0][31:0]  h_i = '0;

    logic [2:0] ready_o_w, valid_o_w, busy_o_w;
    logic [3:0][31:0] h_o_w [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        md5_compress_core #(.UNROLL(1 << k), .W(32)) u_dut (
            .clk_i   (clk),
            .rst_i   (rst_i),
            .valid_i (valid_i),
            .ready_o (ready_o_w[k]),
            .M_i     (m_i),
            .H_i     (h_i),
            .init_i  (init_i),
            .valid_o (valid_o_w[k]),
            .ready_i (ready_i),
            .H_o     (h_o_w[k]),
            .busy_o  (busy_o_w[k])
        );
    end

    typedef struct {
        logic [3:0][31:0] dig;
        int unsigned      acc;
        logic [2:0]       mask;
    } exp_t;

    exp_t exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned rd [3] = '{0, 0, 0};
    logic [2:0] pres = '0;
    logic [2:0] post_hs = '0;
    logic [3:0][31:0] cur [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic int unsigned pending(input int k);
        int unsigned n = 0;
        for (int i = int'(rd[k]); i < exp_q.size(); i++) if (exp_q[i].mask[k]) n++;
        return n;
    endfunction

    // Monitor: one lane per core; latency counts the acceptance edge as cycle 1.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_i) begin
                pres[k] = 1'b0;
                post_hs[k] = 1'b0;
            end else if (post_hs[k]) begin
                chk($sformatf("lane%0d valid_o/ready_o after handshake", k),
                    {valid_o_w[k], ready_o_w[k]}, 2'b01);
                chk($sformatf("lane%0d H_o kept after done", k), h_o_w[k], cur[k]);
                post_hs[k] = 1'b0;
            end else if (valid_o_w[k]) begin
                if (!pres[k]) begin
                    while (rd[k] < exp_q.size() && !exp_q[rd[k]].mask[k]) rd[k]++;
                    if (rd[k] >= exp_q.size()) begin
                        checks++;
                        errors++;
                        $display("FAIL lane%0d unexpected digest: got %h want none", k, h_o_w[k]);
                        cur[k] = h_o_w[k];
                    end else begin
                        cur[k] = exp_q[rd[k]].dig;
                        chk($sformatf("lane%0d digest", k), h_o_w[k], cur[k]);
                        chk($sformatf("lane%0d latency", k), cyc - exp_q[rd[k]].acc,
                            (64 >> k) + 2);
                        rd[k]++;
                    end
                    pres[k] = 1'b1;
                end else begin
                    chk($sformatf("lane%0d H_o held in done", k), h_o_w[k], cur[k]);
                end
                if (ready_i) begin
                    pres[k] = 1'b0;
                    post_hs[k] = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (ready_o_w !== 3'b111 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle before issue", ready_o_w, 3'b111);
    endtask

    task automatic push_exp(input logic [3:0][31:0] dig);
        exp_t e;
        e.dig = dig;
        e.acc = cyc;
        e.mask = 3'b111;
        exp_q.push_back(e);
    endtask

    task automatic scramble();
        for (int j = 0; j < 16; j++) m_i[j] = $urandom();
        for (int j = 0; j < 4; j++) h_i[j] = $urandom();
        init_i = ~init_i;
    endtask

    // Offer one block for a single cycle, then garble the inputs.
    task automatic issue(input logic [15:0][31:0] m, input logic [3:0][31:0] h, input logic init,
                         input logic [3:0][31:0] dig);
        wait_idle();
        m_i = m;
        h_i = h;
        init_i = init;
        valid_i = 1'b1;
        push_exp(dig);
        @(posedge clk); #1;
        valid_i = 1'b0;
        scramble();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((pending(0) + pending(1) + pending(2) != 0 || busy_o_w != 3'b000) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        for (int k = 0; k < 3; k++) chk($sformatf("lane%0d all blocks answered", k), pending(k), 0);
    endtask

    logic [15:0][31:0] m_empty, m_abc;
    logic [3:0][31:0] h_junk;

    initial begin
        m_empty = '0;
        m_empty[0] = 32'h00000080;
        m_abc = '0;
        m_abc[0] = 32'h80636261;
        m_abc[14] = 32'h00000018;
        h_junk = {32'h01234567, 32'h89abcdef, 32'hdeadbeef, 32'hcafef00d};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("ready_o in reset", ready_o_w, 3'b000);
        chk("valid_o in reset", valid_o_w, 3'b000);
        chk("busy_o in reset", busy_o_w, 3'b000);
        for (int k = 0; k < 3; k++) chk($sformatf("lane%0d H_o in reset", k), h_o_w[k], 128'h0);
        rst_i = 1'b1;
        #1;
        chk("ready_o after release", ready_o_w, 3'b111);

        // Known-answer vectors, accepted on the first edge after release.
        issue(m_empty, h_junk, 1'b1, DIG_EMPTY);
        issue(m_abc, h_junk, 1'b1, DIG_ABC);
        issue(m_empty, MD5_IV, 1'b0, DIG_EMPTY);
        wait_drain();

        // Backpressure: hold every lane in DONE for 20 cycles past the slowest one.
        ready_i = 1'b0;
        issue(m_abc, h_junk, 1'b1, DIG_ABC);
        for (int n = 0; n < 200 && valid_o_w[0] !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        chk("backpressure lane0 valid", valid_o_w[0], 1'b1);
        repeat (20) begin
            @(posedge clk); #1;
            chk("valid_o held under backpressure", valid_o_w, 3'b111);
        end
        ready_i = 1'b1;
        wait_drain();

        // Busy: valid_i stays high and M_i changes while all lanes run.
        wait_idle();
        m_i = m_empty;
        h_i = h_junk;
        init_i = 1'b1;
        valid_i = 1'b1;
        push_exp(DIG_EMPTY);
        repeat (10) begin
            @(posedge clk); #1;
            m_i = m_abc;
            m_i[3] = $urandom();
            init_i = 1'b0;
            h_i[1] = $urandom();
        end
        valid_i = 1'b0;
        wait_drain();

        // Reset after 30 edges: UNROLL 1 and 2 are mid-run and drop the block.
        issue(m_abc, h_junk, 1'b1, DIG_ABC);
        repeat (29) @(posedge clk);
        #1;
        begin
            exp_t e;
            e = exp_q[exp_q.size() - 1];
            e.mask = 3'b100;
            exp_q[exp_q.size() - 1] = e;
        end
        rst_i = 1'b0;
        #1;
        chk("ready_o during mid-run reset", ready_o_w, 3'b000);
        chk("valid_o during mid-run reset", valid_o_w, 3'b000);
        chk("busy_o during mid-run reset", busy_o_w, 3'b000);
        for (int k = 0; k < 3; k++) chk($sformatf("lane%0d H_o cleared", k), h_o_w[k], 128'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("ready_o still low in reset", ready_o_w, 3'b000);
        rst_i = 1'b1;
        #1;
        chk("ready_o after mid-run release", ready_o_w, 3'b111);
        issue(m_abc, h_junk, 1'b1, DIG_ABC);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
